// File: rtl/edge_event_arbiter_if.sv
// Event-arbiter bus: edge pulses and control in, one arbitrated event out.
// The slave modport is the arbiter's side; the master modport is the producer/consumer side.
interface edge_event_arbiter_if #(
  parameter int numchannels = 4
);
  logic [numchannels-1:0] risepulse;
  logic [numchannels-1:0] fallpulse;
  logic                   evt_ready;
  logic                   clear_overflow;
  logic                   evt_valid;
  logic [1:0]             evt_channel;
  logic                   evt_rising;
  logic [numchannels-1:0] overflow;
  logic                   busy;

  modport slave (
    input  risepulse, fallpulse, evt_ready, clear_overflow,
    output evt_valid, evt_channel, evt_rising, overflow, busy
  );

  modport master (
    output risepulse, fallpulse, evt_ready, clear_overflow,
    input  evt_valid, evt_channel, evt_rising, overflow, busy
  );
endinterface

// File: rtl/edge_event_arbiter.sv
// Collects per-channel rise/fall edge pulses and presents them one at a time
// through a valid/ready output, round-robin across channels, oldest first within a channel.
module edge_event_arbiter #(
  parameter int numchannels = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  edge_event_arbiter_if.slave   bus
);

  typedef enum logic {IDLE, PRESENT} state_t;

  state_t                 state_q, state_d;
  logic [numchannels-1:0] rise_pend_q, rise_pend_d;
  logic [numchannels-1:0] fall_pend_q, fall_pend_d;
  logic [numchannels-1:0] fall_older_q, fall_older_d;
  logic [numchannels-1:0] overflow_q, overflow_d;
  logic [1:0]             last_q, last_d;
  logic [1:0]             evt_channel_q, evt_channel_d;
  logic                   evt_rising_q, evt_rising_d;

  logic                   any_pend;
  logic                   load_en;
  logic                   sel_found;
  logic [1:0]             sel_ch;
  logic [1:0]             cand;
  logic                   sel_rise;
  logic [numchannels-1:0] rise_first;
  logic [numchannels-1:0] grant_rise;
  logic [numchannels-1:0] grant_fall;
  logic [numchannels-1:0] rise_rem;
  logic [numchannels-1:0] fall_rem;
  logic [numchannels-1:0] ovf_set;

  assign any_pend = |(rise_pend_q | fall_pend_q);

  // Rise goes first unless a falling event is pending and is the older one.
  generate
    for (genvar gi = 0; gi < numchannels; gi++) begin : g_chan
      assign rise_first[gi] = rise_pend_q[gi] & ~(fall_pend_q[gi] & fall_older_q[gi]);
      assign grant_rise[gi] = load_en & (sel_ch == 2'(gi)) & sel_rise;
      assign grant_fall[gi] = load_en & (sel_ch == 2'(gi)) & ~sel_rise;
    end
  endgenerate

  // Round-robin search starting one past the last granted channel.
  always_comb begin
    sel_found = 1'b0;
    sel_ch    = '0;
    cand      = '0;
    for (int k = 1; k <= numchannels; k++) begin
      cand = last_q + 2'(k);
      if (!sel_found && (rise_pend_q[cand] || fall_pend_q[cand])) begin
        sel_found = 1'b1;
        sel_ch    = cand;
      end
    end
    sel_rise = rise_first[sel_ch];
  end

  always_comb begin
    state_d       = state_q;
    load_en       = 1'b0;
    evt_channel_d = evt_channel_q;
    evt_rising_d  = evt_rising_q;
    last_d        = last_q;
    case (state_q)
      IDLE: begin
        if (any_pend) begin
          load_en = 1'b1;
          state_d = PRESENT;
        end
      end
      PRESENT: begin
        if (bus.evt_ready) begin
          if (any_pend) begin
            load_en = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (load_en) begin
      evt_channel_d = sel_ch;
      evt_rising_d  = sel_rise;
      last_d        = sel_ch;
    end
  end

  // A pulse only overflows if its bit is still pending after this cycle's grant.
  always_comb begin
    rise_rem     = rise_pend_q & ~grant_rise;
    fall_rem     = fall_pend_q & ~grant_fall;
    rise_pend_d  = rise_rem | bus.risepulse;
    fall_pend_d  = fall_rem | bus.fallpulse;
    ovf_set      = (bus.risepulse & rise_rem) | (bus.fallpulse & fall_rem);
    fall_older_d = '0;
    for (int i = 0; i < numchannels; i++) begin
      if (rise_rem[i] && fall_rem[i]) begin
        fall_older_d[i] = fall_older_q[i];
      end else begin
        fall_older_d[i] = fall_rem[i];
      end
    end
    overflow_d = (bus.clear_overflow ? '0 : overflow_q) | ovf_set;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      rise_pend_q   <= '0;
      fall_pend_q   <= '0;
      fall_older_q  <= '0;
      overflow_q    <= '0;
      last_q        <= 2'd3;
      evt_channel_q <= '0;
      evt_rising_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      rise_pend_q   <= rise_pend_d;
      fall_pend_q   <= fall_pend_d;
      fall_older_q  <= fall_older_d;
      overflow_q    <= overflow_d;
      last_q        <= last_d;
      evt_channel_q <= evt_channel_d;
      evt_rising_q  <= evt_rising_d;
    end
  end

  assign bus.evt_valid   = (state_q == PRESENT);
  assign bus.evt_channel = evt_channel_q;
  assign bus.evt_rising  = evt_rising_q;
  assign bus.overflow    = overflow_q;
  assign bus.busy        = (state_q == PRESENT) | any_pend;

endmodule

// File: tb/tb_edge_event_arbiter.sv
// Randomized bench: an event-list reference model predicts each presented event into
// a queue; a negedge monitor pops and compares, and also checks valid/overflow/busy.
module tb_edge_event_arbiter;

  logic clk;
  logic reset;

  edge_event_arbiter_if #(.numchannels(4)) bus ();

  edge_event_arbiter #(.numchannels(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int ch;
    bit rise;
  } ev_t;

  ev_t  exp_q[$];
  int   total = 0;
  int   bad   = 0;

  // Reference model: each channel keeps an arrival-ordered list of at most one rise and one fall.
  int       m_cnt[4];
  bit       m_ev[4][2];
  bit       m_valid;
  int       m_last;
  bit [3:0] m_ovf;
  bit       m_busy;
  bit       m_started = 1'b0;

  function automatic bit has_event(int ch, bit kind);
    for (int j = 0; j < m_cnt[ch]; j++)
      if (m_ev[ch][j] == kind) return 1'b1;
    return 1'b0;
  endfunction

  task automatic add_event(int ch, bit kind);
    if (has_event(ch, kind)) begin
      m_ovf[ch] = 1'b1;
    end else begin
      m_ev[ch][m_cnt[ch]] = kind;
      m_cnt[ch]++;
    end
  endtask

  task automatic model_step();
    bit [3:0] rp;
    bit [3:0] fp;
    bit       rdy;
    bit       clr;
    bit       any;
    ev_t      e;
    rp  = bus.risepulse;
    fp  = bus.fallpulse;
    rdy = bus.evt_ready;
    clr = bus.clear_overflow;
    m_started = 1'b1;
    if (reset) begin
      for (int i = 0; i < 4; i++) m_cnt[i] = 0;
      m_valid = 1'b0;
      m_last  = 3;
      m_ovf   = '0;
      m_busy  = 1'b0;
      exp_q.delete();
      return;
    end
    any = 1'b0;
    for (int i = 0; i < 4; i++) if (m_cnt[i] > 0) any = 1'b1;
    if (any && (!m_valid || rdy)) begin
      for (int k = 1; k <= 4; k++) begin
        int c;
        c = (m_last + k) % 4;
        if (m_cnt[c] > 0) begin
          e.ch   = c;
          e.rise = m_ev[c][0];
          m_ev[c][0] = m_ev[c][1];
          m_cnt[c]--;
          m_last = c;
          break;
        end
      end
      exp_q.push_back(e);
      m_valid = 1'b1;
    end else if (m_valid && rdy) begin
      m_valid = 1'b0;
    end
    if (clr) m_ovf = '0;
    for (int i = 0; i < 4; i++) begin
      if (rp[i]) add_event(i, 1'b1);
      if (fp[i]) add_event(i, 1'b0);
    end
    m_busy = m_valid;
    for (int i = 0; i < 4; i++) if (m_cnt[i] > 0) m_busy = 1'b1;
  endtask

  always @(posedge clk) model_step();

  // Monitor: a new event appears whenever valid is high and the previous cycle did not stall.
  bit       prev_valid = 1'b0;
  bit       prev_ready = 1'b0;
  int       held_ch    = 0;
  bit       held_rise  = 1'b0;

  always @(negedge clk) begin
    if (m_started) begin
      total++;
      if (bus.evt_valid !== m_valid) begin
        bad++;
        $display("FAIL evt_valid: got %b expected %b at %0t", bus.evt_valid, m_valid, $time);
      end
      total++;
      if (bus.overflow !== m_ovf) begin
        bad++;
        $display("FAIL overflow: got %b expected %b at %0t", bus.overflow, m_ovf, $time);
      end
      total++;
      if (bus.busy !== m_busy) begin
        bad++;
        $display("FAIL busy: got %b expected %b at %0t", bus.busy, m_busy, $time);
      end
      if (bus.evt_valid === 1'b1) begin
        if (prev_valid && !prev_ready) begin
          total++;
          if (bus.evt_channel !== 2'(held_ch) || bus.evt_rising !== held_rise) begin
            bad++;
            $display("FAIL hold: got ch=%0d rise=%b expected ch=%0d rise=%b at %0t",
                     bus.evt_channel, bus.evt_rising, held_ch, held_rise, $time);
          end
        end else begin
          total++;
          if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL event: got ch=%0d rise=%b expected none at %0t",
                     bus.evt_channel, bus.evt_rising, $time);
          end else begin
            ev_t e;
            e = exp_q.pop_front();
            if (bus.evt_channel !== 2'(e.ch) || bus.evt_rising !== e.rise) begin
              bad++;
              $display("FAIL event: got ch=%0d rise=%b expected ch=%0d rise=%b at %0t",
                       bus.evt_channel, bus.evt_rising, e.ch, e.rise, $time);
            end else begin
              $display("event ch=%0d rise=%b at %0t", bus.evt_channel, bus.evt_rising, $time);
            end
          end
          held_ch   = int'(bus.evt_channel);
          held_rise = bus.evt_rising;
        end
      end
    end
    prev_valid = (bus.evt_valid === 1'b1);
    prev_ready = bus.evt_ready;
  end

  task automatic drive(bit rst, bit [3:0] rp, bit [3:0] fp, bit rdy, bit clr);
    @(posedge clk);
    #1;
    reset              = rst;
    bus.risepulse      = rp;
    bus.fallpulse      = fp;
    bus.evt_ready      = rdy;
    bus.clear_overflow = clr;
  endtask

  function automatic bit [3:0] rand_bits(int pct);
    bit [3:0] v;
    v = '0;
    for (int i = 0; i < 4; i++) v[i] = ($urandom_range(99) < pct);
    return v;
  endfunction

  initial begin
    reset              = 1'b1;
    bus.risepulse      = '0;
    bus.fallpulse      = '0;
    bus.evt_ready      = 1'b0;
    bus.clear_overflow = 1'b0;
    repeat (3) drive(1'b1, 4'b0, 4'b0, 1'b0, 1'b0);

    // Single rising pulse on channel 2, then round-robin burst on all channels.
    drive(1'b0, 4'b0100, 4'b0, 1'b1, 1'b0);
    repeat (5) drive(1'b0, 4'b0, 4'b0, 1'b1, 1'b0);
    drive(1'b0, 4'b1111, 4'b0, 1'b1, 1'b0);
    repeat (6) drive(1'b0, 4'b0, 4'b0, 1'b1, 1'b0);

    // Fall then rise on channel 1 under stall, then overflow on channel 0 and clear.
    drive(1'b0, 4'b0, 4'b0010, 1'b0, 1'b0);
    drive(1'b0, 4'b0, 4'b0, 1'b0, 1'b0);
    drive(1'b0, 4'b0010, 4'b0, 1'b0, 1'b0);
    repeat (3) drive(1'b0, 4'b0, 4'b0, 1'b0, 1'b0);
    repeat (4) drive(1'b0, 4'b0, 4'b0, 1'b1, 1'b0);
    for (int p = 0; p < 3; p++) begin
      drive(1'b0, 4'b0001, 4'b0, 1'b0, 1'b0);
      repeat (2) drive(1'b0, 4'b0, 4'b0, 1'b0, 1'b0);
    end
    repeat (10) drive(1'b0, 4'b0, 4'b0, 1'b0, 1'b0);
    repeat (4) drive(1'b0, 4'b0, 4'b0, 1'b1, 1'b0);
    drive(1'b0, 4'b0, 4'b0, 1'b1, 1'b1);
    drive(1'b0, 4'b0, 4'b0, 1'b1, 1'b0);

    // Reset with one event presented and others pending.
    drive(1'b0, 4'b1011, 4'b0, 1'b0, 1'b0);
    repeat (2) drive(1'b0, 4'b0, 4'b0, 1'b0, 1'b0);
    drive(1'b1, 4'b0110, 4'b0001, 1'b0, 1'b0);
    drive(1'b0, 4'b1001, 4'b0, 1'b1, 1'b0);
    repeat (4) drive(1'b0, 4'b0, 4'b0, 1'b1, 1'b0);

    // Randomized blocks with varying pulse density and consumer readiness.
    for (int blk = 0; blk < 20; blk++) begin
      int pulse_pct;
      int ready_pct;
      pulse_pct = $urandom_range(40, 2);
      ready_pct = $urandom_range(100, 10);
      for (int cyc = 0; cyc < 150; cyc++) begin
        drive(($urandom_range(399) == 0),
              rand_bits(pulse_pct),
              rand_bits(pulse_pct),
              ($urandom_range(99) < ready_pct),
              ($urandom_range(29) == 0));
      end
    end

    repeat (20) drive(1'b0, 4'b0, 4'b0, 1'b1, 1'b0);
    @(negedge clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d undelivered events expected 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/edge_event_arbiter.md
EDGE_EVENT_ARBITER -- requirements
Module: edge_event_arbiter

Interface
REQ-001 Parameter: numchannels, default 4, number of input conditioner channels served; fixed at 4 for this revision.
REQ-002 Port: clk  input  1  single clock domain for all logic.
REQ-003 Port: reset  input  1  reset, synchronous, active-high, sampled on rising clk.
REQ-004 Port: risepulse  input  4  per-channel 1-clk rising-edge pulses from input conditioners.
REQ-005 Port: fallpulse  input  4  per-channel 1-clk falling-edge pulses from input conditioners.
REQ-006 Port: evt_ready  input  1  consumer accepts the presented event this cycle.
REQ-007 Port: clear_overflow  input  1  clears all overflow flags.
REQ-008 Port: evt_valid  output  1  event presented on evt_channel/evt_rising.
REQ-009 Port: evt_channel  output  2  channel index of the presented event.
REQ-010 Port: evt_rising  output  1  1 = rising event, 0 = falling event.
REQ-011 Port: overflow  output  4  sticky per-channel dropped-event flags.
REQ-012 Port: busy  output  1  high when any event is pending or presented.

Function
REQ-013 Each channel SHALL hold two pending bits (rise_pend, fall_pend) plus an order bit that marks which of the two pending events is older.
REQ-014 A pulse on risepulse[i] or fallpulse[i] SHALL set the matching pending bit at the next clk edge.
REQ-015 A pulse arriving while its pending bit is already set and not being granted that cycle SHALL be dropped and SHALL set overflow[i].
REQ-016 A pulse arriving in the same cycle its pending bit is granted SHALL re-set the bit and SHALL NOT set overflow.
REQ-017 Rising and falling pulses on one channel in the same cycle SHALL both be captured, with rising treated as older.
REQ-018 When both pending bits of a channel are set, the older event SHALL be granted first.
REQ-019 Arbitration SHALL be round-robin: search starts at the channel after the last granted channel, wrapping 3->0. After reset the last granted channel is 3, so the search starts at channel 0.
REQ-020 The controller SHALL have two states. IDLE: evt_valid=0. PRESENT: evt_valid=1.
REQ-021 IDLE -> PRESENT when any pending bit is set. The selected event SHALL be loaded into the output registers and its pending bit cleared on the same edge.
REQ-022 PRESENT with evt_ready=0 SHALL hold evt_channel and evt_rising stable.
REQ-023 PRESENT with evt_ready=1 SHALL load the next arbitrated event on the same edge if one is pending, keeping evt_valid=1; otherwise it SHALL go to IDLE.
REQ-024 Latency: a pulse at edge N with the block idle SHALL produce evt_valid=1 after edge N+2. Sustained throughput SHALL be one event per cycle.
REQ-025 Pulses captured on the same edge that the output loads SHALL NOT be eligible until the following cycle.
REQ-026 clear_overflow SHALL zero overflow at the next edge. An overflow event in that same cycle SHALL take priority, leaving that bit set.
REQ-027 busy SHALL equal evt_valid OR any pending bit.

Reset
REQ-028 reset=1 SHALL, at the next edge, clear all pending and order bits, overflow=0, evt_valid=0, evt_channel=0, evt_rising=0, state IDLE, and last granted channel=3.
REQ-029 Pulses present while reset=1 SHALL be discarded. A presented but unaccepted event SHALL be lost when reset is asserted mid-operation.

Verification
REQ-030 Idle channel: risepulse=4'b0100 for one cycle -> after 2 edges, evt_valid=1, evt_channel=2, evt_rising=1; evt_ready=1 -> evt_valid=0 next edge.
REQ-031 Round-robin: risepulse=4'b1111 one cycle, evt_ready held 1 -> channels 0,1,2,3 on four consecutive cycles with no gap.
REQ-032 Order: fallpulse[1] then risepulse[1] two cycles later, evt_ready=0 until both are pending -> falling event presented first, then rising.
REQ-033 Overflow: evt_ready=0, three risepulse[0] pulses spaced 3 cycles apart -> overflow=4'b0001 and only two rising events delivered; clear_overflow -> overflow=0.
REQ-034 Backpressure: evt_ready=0 for 10 cycles -> evt_channel and evt_rising unchanged and evt_valid=1 throughout.
REQ-035 Reset mid-operation: reset=1 with an event presented and two pending -> next edge evt_valid=0, busy=0, overflow=0; first grant after reset is channel 0.
